adder_tree: RTL and testbench

ADDER_TREE -- requirements
Module: adder_tree

---
 rtl/adder_tree_pkg.sv | 21 ++
 rtl/adder_tree_level.sv | 38 +++
 rtl/adder_tree.sv | 96 +++++++++
 tb/tb_adder_tree.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// rtl/adder_tree_pkg.sv - shared sizing helpers for the pipelined adder tree
package adder_tree_pkg;

    function automatic int tree_levels(input int n_inputs);
        int levels = 0;
        while ((1 << levels) < n_inputs) levels++;
        return levels;
    endfunction

    function automatic int sum_width(input int width, input int n_inputs);
        return width + tree_levels(n_inputs);
    endfunction

    // Number of terms entering reduction level `level` (level 0 sees all operands).
    function automatic int level_terms(input int n_inputs, input int level);
        int terms = n_inputs;
        for (int l = 0; l < level; l++) terms = (terms + 1) / 2;
        return terms;
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered level of pairwise additions
module adder_tree_level #(
    parameter int IN_TERMS = 2,
    parameter int WIDTH = 9,
    localparam int OUT_TERMS = (IN_TERMS + 1) / 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [IN_TERMS*WIDTH-1:0]  in_data,
    output logic                       out_valid,
    output logic [OUT_TERMS*WIDTH-1:0] out_data
);

    logic [OUT_TERMS*WIDTH-1:0] next_data;

    for (genvar k = 0; k < OUT_TERMS; k++) begin : g_term
        if (2 * k + 1 < IN_TERMS) begin : g_pair
            assign next_data[k*WIDTH +: WIDTH] = in_data[2*k*WIDTH +: WIDTH]
                                               + in_data[(2*k+1)*WIDTH +: WIDTH];
        end else begin : g_pass
            // Odd term count: the last term rides through unchanged.
            assign next_data[k*WIDTH +: WIDTH] = in_data[2*k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= next_data;
        end
    end

endmodule

// File: rtl/adder_tree.sv
// rtl/adder_tree.sv - pipelined full-precision adder tree with valid/ready flow control
module adder_tree
    import adder_tree_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_INPUTS = 3,
    parameter int SIGNED = 0,
    localparam int LEVELS = tree_levels(N_INPUTS),
    localparam int SUM_W = sum_width(WIDTH, N_INPUTS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_INPUTS*WIDTH-1:0] i_operands,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [SUM_W-1:0]          o_sum
);

    localparam int BUS_W = N_INPUTS * SUM_W;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "adder_tree: WIDTH must be in 1..32");
    end
    if (N_INPUTS < 2 || N_INPUTS > 16) begin : g_bad_count
        $fatal(1, "adder_tree: N_INPUTS must be in 2..16");
    end
    if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
        $fatal(1, "adder_tree: SIGNED must be 0 or 1");
    end

    logic             en;
    logic [BUS_W-1:0] operands_ext;
    logic [BUS_W-1:0] s0_data;
    logic             s0_valid;
    logic [BUS_W-1:0] stage_data [LEVELS+1];
    logic             stage_valid [LEVELS+1];

    // Widen up front so no level can overflow.
    always_comb begin
        operands_ext = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            operands_ext[k*SUM_W +: SUM_W] =
                {{LEVELS{(SIGNED != 0) && i_operands[k*WIDTH + WIDTH - 1]}},
                 i_operands[k*WIDTH +: WIDTH]};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s0_valid <= 1'b0;
            s0_data  <= '0;
        end else if (en) begin
            s0_valid <= i_valid;
            if (i_valid) s0_data <= operands_ext;
        end
    end

    assign stage_data[0]  = s0_data;
    assign stage_valid[0] = s0_valid;

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int IN_TERMS  = level_terms(N_INPUTS, l);
        localparam int OUT_TERMS = (IN_TERMS + 1) / 2;
        logic [OUT_TERMS*SUM_W-1:0] level_data;

        adder_tree_level #(
            .IN_TERMS (IN_TERMS),
            .WIDTH    (SUM_W)
        ) u_level (
            .clk       (i_clk),
            .rst_n     (i_rst_n),
            .en        (en),
            .in_valid  (stage_valid[l]),
            .in_data   (stage_data[l][IN_TERMS*SUM_W-1:0]),
            .out_valid (stage_valid[l+1]),
            .out_data  (level_data)
        );

        assign stage_data[l+1] = BUS_W'(level_data);
    end

    // Upper bus lanes beyond each level's live terms are zero padding.
    logic unused_lanes;
    always_comb begin
        unused_lanes = 1'b0;
        for (int l = 0; l <= LEVELS; l++) unused_lanes = unused_lanes ^ (^stage_data[l]);
    end

    assign en      = i_ready || !stage_valid[LEVELS];
    assign o_ready = en;
    assign o_valid = stage_valid[LEVELS];
    assign o_sum   = stage_data[LEVELS][SUM_W-1:0];

endmodule

// File: tb/tb_adder_tree.sv
// tb/tb_adder_tree.sv - randomized self-checking bench for adder_tree across parameter corners
module tb_adder_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    logic a_valid, a_oready, a_ovalid, a_iready;
    logic [23:0]  a_ops;
    logic [9:0]   a_sum;
    logic b_valid, b_oready, b_ovalid, b_iready;
    logic [31:0]  b_ops;
    logic [9:0]   b_sum;
    logic c_valid, c_oready, c_ovalid, c_iready;
    logic [39:0]  c_ops;
    logic [10:0]  c_sum;
    logic d_valid, d_oready, d_ovalid, d_iready;
    logic [1:0]   d_ops;
    logic [1:0]   d_sum;
    logic e_valid, e_oready, e_ovalid, e_iready;
    logic [511:0] e_ops;
    logic [35:0]  e_sum;

    adder_tree #(.WIDTH(8), .N_INPUTS(3), .SIGNED(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_oready),
        .i_operands(a_ops), .o_valid(a_ovalid), .i_ready(a_iready), .o_sum(a_sum));
    adder_tree #(.WIDTH(8), .N_INPUTS(4), .SIGNED(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_oready),
        .i_operands(b_ops), .o_valid(b_ovalid), .i_ready(b_iready), .o_sum(b_sum));
    adder_tree #(.WIDTH(8), .N_INPUTS(5), .SIGNED(0)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(c_valid), .o_ready(c_oready),
        .i_operands(c_ops), .o_valid(c_ovalid), .i_ready(c_iready), .o_sum(c_sum));
    adder_tree #(.WIDTH(1), .N_INPUTS(2), .SIGNED(0)) dut_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(d_valid), .o_ready(d_oready),
        .i_operands(d_ops), .o_valid(d_ovalid), .i_ready(d_iready), .o_sum(d_sum));
    adder_tree #(.WIDTH(32), .N_INPUTS(16), .SIGNED(1)) dut_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(e_valid), .o_ready(e_oready),
        .i_operands(e_ops), .o_valid(e_ovalid), .i_ready(e_iready), .o_sum(e_sum));

    function automatic int ref_c(input logic [39:0] ops);
        int s = 0;
        for (int k = 0; k < 5; k++) s += int'(ops[k*8 +: 8]);
        return s;
    endfunction

    function automatic longint ref_e(input logic [511:0] ops);
        longint s = 0;
        for (int k = 0; k < 16; k++) s += longint'($signed(ops[k*32 +: 32]));
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_c();
        for (int k = 0; k < 5; k++) c_ops[k*8 +: 8] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        total_cnt++; if (c_ovalid !== 1'b0) $display("FAIL reset_ovalid: got %b expected 0", c_ovalid); else pass_cnt++;
        total_cnt++; if (c_sum !== 11'd0) $display("FAIL reset_sum: got %0d expected 0", c_sum); else pass_cnt++;
        total_cnt++; if (c_oready !== 1'b1) $display("FAIL reset_oready: got %b expected 1", c_oready); else pass_cnt++;
        total_cnt++; if (e_ovalid !== 1'b0) $display("FAIL reset_e_ovalid: got %b expected 0", e_ovalid); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++; if (c_oready !== 1'b1) $display("FAIL post_reset_oready: got %b expected 1", c_oready); else pass_cnt++;
        tick();
    endtask

    task automatic test_full_scale();
        int first = -1;
        logic [9:0] got = '0;
        a_iready = 1'b1;
        a_valid = 1'b1;
        a_ops = {8'd255, 8'd255, 8'd255};
        @(negedge clk);
        total_cnt++; if (a_oready !== 1'b1) $display("FAIL full_capture_ready: got %b expected 1", a_oready); else pass_cnt++;
        tick();
        a_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (a_ovalid === 1'b1 && first < 0) begin
                first = k;
                got = a_sum;
            end
            tick();
        end
        total_cnt++; if (first != 3) $display("FAIL full_latency: got %0d expected 3", first); else pass_cnt++;
        total_cnt++; if (got !== 10'd765) $display("FAIL full_sum: got %0d expected 765", got); else pass_cnt++;
    endtask

    task automatic test_signed();
        logic [9:0] res [2];
        int n = 0;
        b_iready = 1'b1;
        b_valid = 1'b1;
        b_ops = {8'h80, 8'h80, 8'h80, 8'h80};
        tick();
        b_ops = {8'd1, 8'd0, 8'hFF, 8'd127};
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (b_ovalid === 1'b1) begin
                if (n < 2) res[n] = b_sum;
                n++;
            end
            tick();
        end
        total_cnt++; if (n != 2) $display("FAIL signed_count: got %0d expected 2", n); else pass_cnt++;
        total_cnt++; if (res[0] !== 10'h200) $display("FAIL signed_min: got %h expected 200", res[0]); else pass_cnt++;
        total_cnt++; if (res[1] !== 10'd127) $display("FAIL signed_mix: got %0d expected 127", res[1]); else pass_cnt++;
    endtask

    task automatic test_stream();
        int exp_q [$];
        int exp, sent = 0, got = 0, first_cyc = -1, last_cyc = -1;
        c_iready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 20) begin
                c_valid = 1'b1;
                randomize_c();
            end else begin
                c_valid = 1'b0;
            end
            @(negedge clk);
            if (c_valid && c_oready) begin
                exp_q.push_back(ref_c(c_ops));
                sent++;
            end
            if (c_ovalid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total_cnt++; if (c_sum !== exp[10:0] || exp < 0) $display("FAIL stream_sum: got %0d expected %0d", c_sum, exp); else pass_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            tick();
        end
        total_cnt++; if (got != 20) $display("FAIL stream_count: got %0d expected 20", got); else pass_cnt++;
        total_cnt++; if (first_cyc != 4) $display("FAIL stream_latency: got %0d expected 4", first_cyc); else pass_cnt++;
        total_cnt++; if (last_cyc - first_cyc != 19) $display("FAIL stream_gapless: got %0d expected 19", last_cyc - first_cyc); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int exp_q [$];
        int exp, sent = 0, got = 0;
        bit need_new = 1'b1;
        logic [10:0] held_sum = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (sent < 12) begin
                if (need_new) begin
                    randomize_c();
                    need_new = 1'b0;
                end
                c_valid = 1'b1;
            end else begin
                c_valid = 1'b0;
            end
            c_iready = !(cyc >= 6 && cyc < 10);
            @(negedge clk);
            if (cyc >= 6 && cyc < 10) begin
                total_cnt++; if (c_oready !== 1'b0) $display("FAIL bp_oready: got %b expected 0", c_oready); else pass_cnt++;
                total_cnt++; if (c_ovalid !== 1'b1) $display("FAIL bp_ovalid: got %b expected 1", c_ovalid); else pass_cnt++;
                if (cyc == 6) held_sum = c_sum;
                else begin
                    total_cnt++; if (c_sum !== held_sum) $display("FAIL bp_hold: got %0d expected %0d", c_sum, held_sum); else pass_cnt++;
                end
            end
            if (c_valid && c_oready) begin
                exp_q.push_back(ref_c(c_ops));
                sent++;
                need_new = 1'b1;
            end
            if (c_ovalid === 1'b1 && c_iready) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                total_cnt++; if (c_sum !== exp[10:0] || exp < 0) $display("FAIL bp_sum: got %0d expected %0d", c_sum, exp); else pass_cnt++;
                got++;
            end
            tick();
        end
        c_iready = 1'b1;
        total_cnt++; if (got != 12) $display("FAIL bp_count: got %0d expected 12", got); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        bit stale = 1'b0;
        int found = -1;
        logic [10:0] got = '0;
        c_iready = 1'b1;
        c_valid = 1'b1;
        randomize_c();
        tick();
        randomize_c();
        tick();
        c_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        total_cnt++; if (c_ovalid !== 1'b0) $display("FAIL midreset_ovalid: got %b expected 0", c_ovalid); else pass_cnt++;
        total_cnt++; if (c_oready !== 1'b1) $display("FAIL midreset_oready: got %b expected 1", c_oready); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (c_ovalid !== 1'b0) stale = 1'b1;
            tick();
        end
        total_cnt++; if (stale) $display("FAIL midreset_stale: got 1 expected 0"); else pass_cnt++;
        c_valid = 1'b1;
        c_ops = {8'd0, 8'd0, 8'd3, 8'd2, 8'd1};
        tick();
        c_valid = 1'b0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (c_ovalid === 1'b1 && found < 0) begin
                found = k;
                got = c_sum;
            end
            tick();
        end
        total_cnt++; if (found != 4) $display("FAIL midreset_new_latency: got %0d expected 4", found); else pass_cnt++;
        total_cnt++; if (got !== 11'd6) $display("FAIL midreset_new_sum: got %0d expected 6", got); else pass_cnt++;
    endtask

    task automatic test_random_corners();
        int d_q [$];
        longint e_q [$];
        int d_exp, d_sent = 0, d_got = 0, e_sent = 0, e_got = 0;
        longint e_exp;
        for (int cyc = 0; cyc < 420; cyc++) begin
            d_valid = (cyc < 360) && ($urandom % 3 != 0);
            e_valid = (cyc < 360) && ($urandom % 3 != 0);
            d_iready = (cyc >= 360) || ($urandom % 4 != 0);
            e_iready = (cyc >= 360) || ($urandom % 4 != 0);
            d_ops = 2'($urandom);
            for (int k = 0; k < 16; k++) e_ops[k*32 +: 32] = $urandom;
            @(negedge clk);
            if (d_valid && d_oready) begin
                d_q.push_back(int'(d_ops[0]) + int'(d_ops[1]));
                d_sent++;
            end
            if (e_valid && e_oready) begin
                e_q.push_back(ref_e(e_ops));
                e_sent++;
            end
            if (d_ovalid === 1'b1 && d_iready) begin
                d_exp = (d_q.size() > 0) ? d_q.pop_front() : -1;
                total_cnt++; if (d_sum !== d_exp[1:0] || d_exp < 0) $display("FAIL rand_d_sum: got %0d expected %0d", d_sum, d_exp); else pass_cnt++;
                d_got++;
            end
            if (e_ovalid === 1'b1 && e_iready) begin
                e_exp = (e_q.size() > 0) ? e_q.pop_front() : 64'sd0;
                total_cnt++; if (e_sum !== e_exp[35:0]) $display("FAIL rand_e_sum: got %h expected %h", e_sum, e_exp[35:0]); else pass_cnt++;
                e_got++;
            end
            tick();
        end
        total_cnt++; if (d_got != d_sent || d_sent == 0) $display("FAIL rand_d_count: got %0d expected %0d", d_got, d_sent); else pass_cnt++;
        total_cnt++; if (e_got != e_sent || e_sent == 0) $display("FAIL rand_e_count: got %0d expected %0d", e_got, e_sent); else pass_cnt++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_iready = 1'b1; a_ops = '0;
        b_valid = 1'b0; b_iready = 1'b1; b_ops = '0;
        c_valid = 1'b0; c_iready = 1'b1; c_ops = '0;
        d_valid = 1'b0; d_iready = 1'b1; d_ops = '0;
        e_valid = 1'b0; e_iready = 1'b1; e_ops = '0;
        #1;
        test_reset();
        test_full_scale();
        test_signed();
        test_stream();
        test_backpressure();
        test_reset_midflight();
        test_random_corners();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
